// File: rtl/mux5_rr_sched_pkg.sv
// Shared definitions for the 5-source round-robin mux scheduler.
// Holds the FSM state encoding, source index constants, select codes and
// a small helper that walks the round-robin ring.
package mux5_rr_sched_pkg;

  localparam int NSRC_FIXED = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Source indices (U,V,W,X,Y)
  localparam logic [2:0] SRC_U = 3'd0;
  localparam logic [2:0] SRC_V = 3'd1;
  localparam logic [2:0] SRC_W = 3'd2;
  localparam logic [2:0] SRC_X = 3'd3;
  localparam logic [2:0] SRC_Y = 3'd4;

  // Mux select codes {s2,s1,s0}
  localparam logic [2:0] SEL_U = 3'b000;
  localparam logic [2:0] SEL_V = 3'b001;
  localparam logic [2:0] SEL_W = 3'b010;
  localparam logic [2:0] SEL_X = 3'b011;
  localparam logic [2:0] SEL_Y = 3'b100;

  // Index reached 'step' positions after 'last' on the 5-entry ring.
  function automatic logic [2:0] rr_index(input logic [2:0] last, input int step);
    int sum;
    sum = (int'(last) + step) % NSRC_FIXED;
    return sum[2:0];
  endfunction

  // Select code for a source index; unknown indices map to SEL_U.
  function automatic logic [2:0] sel_of(input logic [2:0] idx);
    logic [2:0] sel;
    case (idx)
      SRC_U:   sel = SEL_U;
      SRC_V:   sel = SEL_V;
      SRC_W:   sel = SEL_W;
      SRC_X:   sel = SEL_X;
      SRC_Y:   sel = SEL_Y;
      default: sel = SEL_U;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mux5_rr_sched_rr_pick5.sv
// Combinational round-robin picker for 5 requesters.
// Ports:
//   req   - request vector, bit i = source i
//   last  - index of the most recently granted source (0..4)
//   gnt   - one-hot pick, all-zero when nothing requests
//   idx   - index of the picked source, 0 when nothing requests
//   valid - high when some source was picked
// The search starts one past 'last' and wraps 4->0, so 'last' itself is
// checked last and a lone requester is picked again.
module rr_pick5
  import mux5_rr_sched_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] last,
  output logic [4:0] gnt,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= NSRC_FIXED; k++) begin
      if (!valid && req[rr_index(last, k)]) begin
        valid = 1'b1;
        idx   = rr_index(last, k);
        gnt   = 5'b00001 << rr_index(last, k);
      end
    end
  end

endmodule

// File: rtl/mux5_rr_sched.sv
// Round-robin scheduler driving a 5:1 source mux (sources U,V,W,X,Y).
// A grant is held for max(Dwell,1) cycles, then one ARB cycle picks the
// next source while the old grant stays visible (no gap). A grant whose
// request drops ends at the next edge.
// Ports:
//   Clock, Resetn    - clock, asynchronous active-low reset
//   Enable           - run enable; low forces IDLE, pointer is kept
//   Req[NSRC-1:0]    - per-source requests
//   Dwell[DWELL_W-1:0] - hold length, sampled when the grant loads
//   s2,s1,s0         - registered mux select
//   Gnt[NSRC-1:0]    - registered one-hot grant
//   SrcId[2:0]       - registered granted index
//   Busy             - high while a grant is held
//   dbg_state        - current FSM state
// Handshake: there is no valid/ready pair; a grant is valid exactly while
// Busy is high, and Gnt/SrcId/select always describe the same source.
module mux5_rr_sched
  import mux5_rr_sched_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int NSRC    = 5
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Enable,
  input  logic [NSRC-1:0]    Req,
  input  logic [DWELL_W-1:0] Dwell,
  output logic               s2,
  output logic               s1,
  output logic               s0,
  output logic [NSRC-1:0]    Gnt,
  output logic [2:0]         SrcId,
  output logic               Busy,
  output state_t             dbg_state
);

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [2:0]         last;
  logic [NSRC-1:0]    gnt_q;
  logic [2:0]         src_q;
  logic [2:0]         sel_q;
  logic               busy_q;

  logic [4:0] pick_gnt;
  logic [2:0] pick_idx;
  logic       pick_valid;

  rr_pick5 u_pick (
    .req   (Req),
    .last  (last),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      last   <= SRC_Y;
      gnt_q  <= '0;
      src_q  <= '0;
      sel_q  <= SEL_U;
      busy_q <= 1'b0;
    end else if (!Enable) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      gnt_q  <= '0;
      src_q  <= '0;
      sel_q  <= SEL_U;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|Req) state <= ST_ARB;
        end
        ST_ARB: begin
          if (pick_valid) begin
            gnt_q  <= pick_gnt;
            src_q  <= pick_idx;
            sel_q  <= sel_of(pick_idx);
            busy_q <= 1'b1;
            last   <= pick_idx;
            cnt    <= (Dwell == '0) ? DWELL_W'(1) : Dwell;
            state  <= ST_HOLD;
          end else begin
            gnt_q  <= '0;
            src_q  <= '0;
            sel_q  <= SEL_U;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!Req[src_q]) begin
            // Granted source went away: drop the grant now.
            gnt_q  <= '0;
            src_q  <= '0;
            sel_q  <= SEL_U;
            busy_q <= 1'b0;
            cnt    <= '0;
            state  <= (|Req) ? ST_ARB : ST_IDLE;
          end else if (cnt <= DWELL_W'(1)) begin
            // Granted source still requests, so Req is non-zero: rearbitrate
            // with the current grant left on the outputs.
            cnt   <= '0;
            state <= ST_ARB;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        default: begin
          gnt_q  <= '0;
          src_q  <= '0;
          sel_q  <= SEL_U;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign Gnt          = gnt_q;
  assign SrcId        = src_q;
  assign {s2, s1, s0} = sel_q;
  assign Busy         = busy_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_mux5_rr_sched.sv
// Bench for mux5_rr_sched: table of per-cycle vectors with expected
// outputs, expected words queued at drive time and popped after the edge,
// hand-written reset sequences, then a random phase with invariant checks.
module tb_mux5_rr_sched;
  import mux5_rr_sched_pkg::*;

  localparam int DW = 8;
  localparam int W  = 14;  // {state, gnt, id, sel, busy}

  logic          Clock = 1'b0;
  logic          Resetn;
  logic          Enable;
  logic [4:0]    Req;
  logic [DW-1:0] Dwell;
  logic          s2, s1, s0;
  logic [4:0]    Gnt;
  logic [2:0]    SrcId;
  logic          Busy;
  state_t        dbg_state;

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  mux5_rr_sched #(.DWELL_W(DW), .NSRC(5)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Enable    (Enable),
    .Req       (Req),
    .Dwell     (Dwell),
    .s2        (s2),
    .s1        (s1),
    .s0        (s0),
    .Gnt       (Gnt),
    .SrcId     (SrcId),
    .Busy      (Busy),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic          rst_first;
    logic          en;
    logic [4:0]    req;
    logic [DW-1:0] dwell;
    logic [4:0]    gnt;
    logic          busy;
    state_t        st;
  } vec_t;

  vec_t          vecs[$];
  logic [W-1:0]  exp_q[$];
  int            n_vec = 0;
  int            n_bad = 0;

  function automatic void add(input logic rf, input logic en, input logic [4:0] req,
                              input int dwell, input logic [4:0] gnt, input logic busy,
                              input state_t st);
    vec_t v;
    v.rst_first = rf;
    v.en        = en;
    v.req       = req;
    v.dwell     = DW'(dwell);
    v.gnt       = gnt;
    v.busy      = busy;
    v.st        = st;
    vecs.push_back(v);
  endfunction

  // Expected output word: id and select follow from the one-hot grant.
  function automatic logic [W-1:0] pack_exp(input logic [4:0] g, input logic b, input state_t st);
    logic [2:0] sel_tab [5];
    logic [2:0] id;
    sel_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    id = 3'd0;
    for (int i = 0; i < 5; i++) if (g[i]) id = 3'(i);
    return {st, g, id, sel_tab[id], b};
  endfunction

  function automatic logic [W-1:0] actual();
    return {dbg_state, Gnt, SrcId, s2, s1, s0, Busy};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name);
    logic [W-1:0] e, a;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: expected queue empty", name);
      return;
    end
    e = exp_q.pop_front();
    a = actual();
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got st=%0d gnt=%b id=%0d sel=%b busy=%b, want st=%0d gnt=%b id=%0d sel=%b busy=%b",
               name, a[13:12], a[11:7], a[6:4], a[3:1], a[0],
               e[13:12], e[11:7], e[6:4], e[3:1], e[0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulses reset with the current inputs left applied; outputs must clear
  // before any clock edge and stay clear while reset is held.
  task automatic do_reset(input string tag);
    Resetn = 1'b0;
    #1;
    exp_q.push_back(pack_exp(5'b0, 1'b0, ST_IDLE));
    check({tag, "_async_reset"});
    @(posedge Clock); #1;
    exp_q.push_back(pack_exp(5'b0, 1'b0, ST_IDLE));
    check({tag, "_reset_held"});
    Resetn = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v, input int i);
    if (v.rst_first) do_reset($sformatf("vec%0d", i));
    Enable = v.en;
    Req    = v.req;
    Dwell  = v.dwell;
    exp_q.push_back(pack_exp(v.gnt, v.busy, v.st));
    @(posedge Clock); #1;
    check($sformatf("vec%0d", i));
  endtask

  function automatic void build_table();
    logic [4:0] oh;
    // Lone requester U, dwell 3: hold 3, one ARB cycle with grant kept.
    add(0, 1, 5'b00001, 3, 5'b00000, 0, ST_ARB);
    for (int r = 0; r < 2; r++) begin
      add(0, 1, 5'b00001, 3, 5'b00001, 1, ST_HOLD);
      add(0, 1, 5'b00001, 3, 5'b00001, 1, ST_HOLD);
      add(0, 1, 5'b00001, 3, 5'b00001, 1, ST_HOLD);
      add(0, 1, 5'b00001, 3, 5'b00001, 1, ST_ARB);
    end
    add(0, 0, 5'b00001, 3, 5'b00000, 0, ST_IDLE);
    // All request, dwell 2: U,V,W,X,Y,U.
    add(1, 1, 5'b11111, 2, 5'b00000, 0, ST_ARB);
    for (int g = 0; g < 6; g++) begin
      oh = 5'b00001 << (g % 5);
      add(0, 1, 5'b11111, 2, oh, 1, ST_HOLD);
      add(0, 1, 5'b11111, 2, oh, 1, ST_HOLD);
      add(0, 1, 5'b11111, 2, oh, 1, ST_ARB);
    end
    // Dwell 0 behaves as 1, source Y only.
    add(1, 1, 5'b10000, 0, 5'b00000, 0, ST_ARB);
    for (int r = 0; r < 3; r++) begin
      add(0, 1, 5'b10000, 0, 5'b10000, 1, ST_HOLD);
      add(0, 1, 5'b10000, 0, 5'b10000, 1, ST_ARB);
    end
    // X with dwell 10, Req[3] drops in 4th HOLD cycle; Y follows.
    add(1, 1, 5'b01000, 10, 5'b00000, 0, ST_ARB);
    for (int r = 0; r < 4; r++) add(0, 1, 5'b01000, 10, 5'b01000, 1, ST_HOLD);
    add(0, 1, 5'b10001, 10, 5'b00000, 0, ST_ARB);
    add(0, 1, 5'b10001, 10, 5'b10000, 1, ST_HOLD);
    add(0, 0, 5'b10001, 10, 5'b00000, 0, ST_IDLE);
    // W held, Enable low, then V wins after wrap; Dwell change mid-HOLD ignored.
    add(1, 1, 5'b00100, 5, 5'b00000, 0, ST_ARB);
    add(0, 1, 5'b00100, 5, 5'b00100, 1, ST_HOLD);
    add(0, 1, 5'b00100, 5, 5'b00100, 1, ST_HOLD);
    add(0, 0, 5'b00110, 5, 5'b00000, 0, ST_IDLE);
    add(0, 1, 5'b00110, 5, 5'b00000, 0, ST_ARB);
    add(0, 1, 5'b00110, 5, 5'b00010, 1, ST_HOLD);
    for (int r = 0; r < 4; r++) add(0, 1, 5'b00110, 1, 5'b00010, 1, ST_HOLD);
    add(0, 1, 5'b00110, 1, 5'b00010, 1, ST_ARB);
    add(0, 1, 5'b00110, 1, 5'b00100, 1, ST_HOLD);
    // V then X, reset lands mid-HOLD of X; first grant after goes to V.
    add(1, 1, 5'b01010, 4, 5'b00000, 0, ST_ARB);
    for (int r = 0; r < 4; r++) add(0, 1, 5'b01010, 4, 5'b00010, 1, ST_HOLD);
    add(0, 1, 5'b01010, 4, 5'b00010, 1, ST_ARB);
    add(0, 1, 5'b01010, 4, 5'b01000, 1, ST_HOLD);
    add(0, 1, 5'b01010, 4, 5'b01000, 1, ST_HOLD);
    add(1, 1, 5'b01010, 4, 5'b00000, 0, ST_ARB);
    add(0, 1, 5'b01010, 4, 5'b00010, 1, ST_HOLD);
  endfunction

  // ---------------- random phase invariants ----------------
  task automatic random_phase(input int cycles);
    logic       was_en;
    logic [2:0] id;
    logic       ok;
    for (int c = 0; c < cycles; c++) begin
      Enable = ($urandom_range(0, 15) != 0);
      Req    = 5'($urandom_range(0, 31));
      Dwell  = DW'($urandom_range(0, 3));
      was_en = Enable;
      @(posedge Clock); #1;
      id = 3'd0;
      for (int i = 0; i < 5; i++) if (Gnt[i]) id = 3'(i);
      ok = ($countones(Gnt) <= 1) && (Busy == (|Gnt)) && (SrcId == id) &&
           ({s2, s1, s0} == id) && (was_en || (dbg_state == ST_IDLE && Gnt == 5'b0)) &&
           (dbg_state != ST_IDLE || Gnt == 5'b0);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL rand%0d: got st=%0d gnt=%b id=%0d sel=%b busy=%b en_before=%b, want one-hot gnt with matching id/sel/busy",
                 c, dbg_state, Gnt, SrcId, {s2, s1, s0}, Busy, was_en);
      end
    end
  endtask

  // ---------------- main ----------------
  initial begin
    Resetn = 1'b0;
    Enable = 1'b0;
    Req    = 5'b0;
    Dwell  = '0;
    #3;
    exp_q.push_back(pack_exp(5'b0, 1'b0, ST_IDLE));
    check("reset_state");
    @(posedge Clock); #1;
    Resetn = 1'b1;

    build_table();
    foreach (vecs[i]) apply_vec(vecs[i], i);

    random_phase(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
